// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer slice.
package word_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2w(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_word_fifo.sv
// Word FIFO ahead of the shifter; head word is always visible on rdata.
module ser_word_fifo
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = clog2w(DEPTH),
  localparam int LW = clog2w(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage needs no reset: level gates every read that matters.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: FIFO-buffered words shifted out one bit per
// cycle, back-to-back with no idle bits while words are pending.
//
// state     | meaning
// ----------+-------------------------------------------------------
// SER_IDLE  | line held at IDLE_BIT, waiting for a queued word
// SER_SHIFT | shift register driving one data bit per cycle
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 2,
  parameter logic IDLE_BIT  = 1'b0,
  parameter int   MSB_FIRST = 0,
  localparam int  LW        = clog2w(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic [LW-1:0]    level,
  output logic             busy
);

  localparam int             CW       = clog2w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam int             OUT_IDX  = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign in_ready   = (level != LW'(DEPTH)) && !reset;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (level == '0);

  ser_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (level)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SER_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and pop; popping on the last bit keeps the stream gapless.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      SER_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (cnt == CNT_LAST) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_nxt = SER_IDLE;
          end
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  // Move the next bit toward the output end.
  always_comb begin
    sreg_shifted = sreg;
    if (MSB_FIRST != 0) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // Shift register and bit counter; cnt returns to 0 when a word ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (pop) begin
      sreg <= head;
      cnt  <= '0;
    end else if (state == SER_SHIFT) begin
      sreg <= sreg_shifted;
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign out       = (state == SER_SHIFT) ? sreg[OUT_IDX] : IDLE_BIT;
  assign out_valid = (state == SER_SHIFT);
  assign busy      = (state == SER_SHIFT) || !fifo_empty;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: LSB-first instance checked bit by bit
// against a queue of expected bits, plus an MSB-first instance.
module tb_word_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       out_valid;
  logic [1:0] level;
  logic       busy;

  logic [7:0] in_data_m;
  logic       in_valid_m;
  logic       in_ready_m;
  logic       out_m;
  logic       out_valid_m;
  logic [1:0] level_m;
  logic       busy_m;

  int   n_checks;
  int   n_fail;
  bit   exp_q[$];
  bit   saw_stall;

  word_serializer #(
    .WIDTH(8), .DEPTH(2), .IDLE_BIT(1'b0), .MSB_FIRST(0)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .level(level), .busy(busy)
  );

  word_serializer #(
    .WIDTH(8), .DEPTH(2), .IDLE_BIT(1'b0), .MSB_FIRST(1)
  ) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data_m), .in_valid(in_valid_m),
    .in_ready(in_ready_m), .out(out_m), .out_valid(out_valid_m),
    .level(level_m), .busy(busy_m)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every valid bit must match the oldest expected bit.
  always @(negedge clk) begin
    bit b;
    if (!reset) begin
      check_val("ready_vs_level", {31'd0, in_ready}, {31'd0, level != 2'd2});
      if (out_valid) begin
        check_val("bit_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check_val("serial_bit", {31'd0, out}, {31'd0, b});
        end
      end else begin
        check_val("idle_out", {31'd0, out}, 32'd0);
      end
    end
  end

  // Push one word on the LSB-first instance; returns just after the push edge.
  task automatic push_word(input logic [7:0] w);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 100) begin
      saw_stall = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_val("push_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hXX;
    end
  endtask

  // Called at a negedge; counts contiguous out_valid cycles of the next run.
  task automatic count_run(output int run);
    int n;
    n = 0;
    run = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("run_start", {31'd0, out_valid}, 32'd1);
    while (out_valid && run < 100) begin
      run++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_busy", {31'd0, busy}, 32'd0);
    check_val("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    logic [7:0] wm;
    n_checks   = 0;
    n_fail     = 0;
    saw_stall  = 1'b0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_valid_m = 1'b0;
    in_data_m  = 8'h00;

    // Reset state
    #3;
    check_val("rst_out", {31'd0, out}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_level", {30'd0, level}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single word 0F: latency and exactly 8 valid cycles
    push_word(8'h0F);
    @(negedge clk);
    check_val("lat_valid_k", {31'd0, out_valid}, 32'd0);
    check_val("lat_level_k", {30'd0, level}, 32'd1);
    @(negedge clk);
    check_val("lat_valid_k1", {31'd0, out_valid}, 32'd1);
    count_run(run);
    check_val("run_0f", run, 32'd8);
    check_val("after_0f_busy", {31'd0, busy}, 32'd0);
    check_val("after_0f_out", {31'd0, out}, 32'd0);

    // Back-to-back A5, 3C: one gapless 16-bit run
    push_word(8'hA5);
    push_word(8'h3C);
    @(negedge clk);
    count_run(run);
    check_val("run_a5_3c", run, 32'd16);
    wait_idle();

    // Four words with valid held: FIFO fills, stalls, nothing lost
    saw_stall = 1'b0;
    push_word(8'h11);
    push_word(8'hC7);
    push_word(8'h6E);
    push_word(8'h93);
    check_val("stall_seen", {31'd0, saw_stall}, 32'd1);
    wait_idle();

    // Pattern 00 then FF for the downstream detector
    push_word(8'h00);
    push_word(8'hFF);
    @(negedge clk);
    count_run(run);
    check_val("run_00_ff", run, 32'd16);
    wait_idle();

    // MSB-first instance with 80
    wm = 8'h80;
    @(negedge clk);
    in_valid_m = 1'b1;
    in_data_m  = wm;
    check_val("msb_ready", {31'd0, in_ready_m}, 32'd1);
    @(posedge clk);
    #1;
    in_valid_m = 1'b0;
    @(negedge clk);
    check_val("msb_lat_valid", {31'd0, out_valid_m}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("msb_valid", {31'd0, out_valid_m}, 32'd1);
      check_val("msb_bit", {31'd0, out_m}, {31'd0, wm[7-i]});
    end
    @(negedge clk);
    check_val("msb_end_valid", {31'd0, out_valid_m}, 32'd0);
    check_val("msb_end_out", {31'd0, out_m}, 32'd0);

    // Reset during bit 3 with one word queued
    push_word(8'hC3);
    push_word(8'h5A);
    @(negedge clk);
    run = 0;
    while (!out_valid && run < 20) begin
      @(negedge clk);
      run++;
    end
    check_val("rst_test_start", {31'd0, out_valid}, 32'd1);
    repeat (3) @(negedge clk);
    check_val("rst_test_queued", {30'd0, level}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_rst_out", {31'd0, out}, 32'd0);
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_level", {30'd0, level}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_val("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("post_rst_level", {30'd0, level}, 32'd0);
    check_val("post_rst_out", {31'd0, out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
